cache_fill_controller: RTL and testbench

//  Multi-requester block-fill engine between the I/D caches and a fixed-latency,

---
 rtl/cache_fill_controller_pkg.sv | 16 +
 rtl/cache_fill_controller_rr_arbiter.sv | 39 +++
 rtl/cache_fill_controller.sv | 198 +++++++++++++++++++
 tb/tb_cache_fill_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_controller_pkg.sv
// Shared types and helpers for the cache block-fill engine.
package cache_fill_controller_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } fill_state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/cache_fill_controller_rr_arbiter.sv
// Requester arbiter: fixed priority (lowest index) or round-robin starting at ptr.
module rr_arbiter
    import cache_fill_controller_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ARB_MODE = 0,
    parameter int PTR_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic found;

    // Scan requesters from the start index, first asserted one wins.
    always_comb begin
        int start;
        int j;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        start   = (ARB_MODE == 1) ? int'(ptr) : 0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = start + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = PTR_W'(j);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_fill_controller.sv
// Block-fill engine: arbitrates cache misses, streams one word address per cycle
// to a pipelined memory and forwards the returned words to the granted cache.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FLUSH | after reset, swallow in-flight memory returns for MEM_LATENCY cycles
// ST_IDLE  | wait for a miss, latch grant and block base address
// ST_ISSUE | one read per cycle, word 0..WPB-1
// ST_DRAIN | all reads issued, collect remaining returns until fill_done
module cache_fill_controller
    import cache_fill_controller_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    parameter int ARB_MODE        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   miss_req,
    input  logic [NUM_REQ*ADDR_W-1:0]            miss_addr,
    output logic [NUM_REQ-1:0]                   fill_busy,
    output logic [NUM_REQ-1:0]                   fill_grant,
    output logic                                 fill_valid,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0]   fill_word_idx,
    output logic [DATA_W-1:0]                    fill_data,
    output logic                                 fill_done,
    output logic                                 mem_en,
    output logic [ADDR_W-1:0]                    mem_addr,
    input  logic [DATA_W-1:0]                    mem_rdata,
    input  logic                                 mem_rvalid,
    output logic                                 err_rvalid
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int OFS_BITS   = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
    localparam int PTR_W      = clog2_min1(NUM_REQ);
    localparam int FL_W       = clog2_min1(MEM_LATENCY);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << OFS_BITS) - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    fill_state_e         state_q, state_d;
    logic [IDX_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    grant_idx_q, grant_idx_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                fill_valid_q, fill_valid_d;
    logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
    logic [DATA_W-1:0]   fill_data_q, fill_data_d;
    logic                fill_done_q, fill_done_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [PTR_W-1:0]    arb_idx;
    logic [ADDR_W-1:0]   req_addr;
    logic                accept_ret;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ARB_MODE (ARB_MODE),
        .PTR_W    (PTR_W)
    ) u_arb (
        .req     (miss_req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Miss address of the requester the arbiter would pick this cycle.
    always_comb begin
        req_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                req_addr = miss_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state, counters, issue strobe and return capture.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        base_d       = base_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        ptr_d        = ptr_q;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        fill_done_d  = 1'b0;
        err_d        = err_q;
        mem_en       = 1'b0;
        mem_addr     = '0;
        // Once fill_done is showing, the block is complete; nothing more belongs to it.
        accept_ret   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN && !fill_done_q);

        case (state_q)
            ST_FLUSH: begin
                if (flush_cnt_q == FL_W'(MEM_LATENCY - 1)) begin
                    flush_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            ST_IDLE: begin
                if (mem_rvalid) begin
                    err_d = 1'b1;
                end
                if (|miss_req) begin
                    grant_d     = arb_gnt;
                    grant_idx_d = arb_idx;
                    base_d      = req_addr & ~BLK_MASK;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en      = 1'b1;
                mem_addr    = base_q + ADDR_W'(issue_cnt_q) * ADDR_W'(WORD_BYTES);
                issue_cnt_d = issue_cnt_q + IDX_W'(1);
                if (issue_cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fill_done_q) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                    if (ARB_MODE == 1) begin
                        ptr_d = (grant_idx_q == PTR_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = ST_FLUSH;
        endcase

        if (accept_ret && mem_rvalid) begin
            fill_valid_d = 1'b1;
            fill_idx_d   = ret_cnt_q;
            fill_data_d  = mem_rdata;
            fill_done_d  = (ret_cnt_q == LAST_IDX);
            ret_cnt_d    = ret_cnt_q + IDX_W'(1);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FLUSH;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            base_q       <= '0;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            ptr_q        <= '0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
            fill_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            base_q       <= base_d;
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            ptr_q        <= ptr_d;
            fill_valid_q <= fill_valid_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
            fill_done_q  <= fill_done_d;
            err_q        <= err_d;
        end
    end

    assign fill_grant    = grant_q;
    assign fill_valid    = fill_valid_q;
    assign fill_word_idx = fill_idx_q;
    assign fill_data     = fill_data_q;
    assign fill_done     = fill_done_q;
    assign err_rvalid    = err_q;
    assign fill_busy     = miss_req & ~(grant_q & {NUM_REQ{fill_done_q}});

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed bench: fixed-priority instance (dut0) and round-robin instance (dut1),
// each attached to a 4-cycle pipelined memory model.
module tb_cache_fill_controller;

    logic        clk;
    logic        rst_n;
    int          n_assert = 0;
    int          n_fail   = 0;

    logic [1:0]  req0, req1;
    logic [31:0] addr0, addr1;
    logic        inj;

    logic [1:0]  busy0, grant0, busy1, grant1;
    logic        valid0, done0, en0, err0, valid1, done1, en1, err1;
    logic [2:0]  idx0, idx1;
    logic [15:0] data0, data1, mem_addr0, mem_addr1;
    logic [15:0] rdata0, rdata1;
    logic        rvalid0, rvalid1;

    logic [3:0]  m0_v = '0;
    logic [3:0]  m1_v = '0;
    logic [15:0] m0_a [4];
    logic [15:0] m1_a [4];

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hBEEF;
    endfunction

    cache_fill_controller #(.ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .miss_req(req0), .miss_addr(addr0),
        .fill_busy(busy0), .fill_grant(grant0), .fill_valid(valid0),
        .fill_word_idx(idx0), .fill_data(data0), .fill_done(done0),
        .mem_en(en0), .mem_addr(mem_addr0), .mem_rdata(rdata0),
        .mem_rvalid(rvalid0), .err_rvalid(err0)
    );

    cache_fill_controller #(.ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .miss_req(req1), .miss_addr(addr1),
        .fill_busy(busy1), .fill_grant(grant1), .fill_valid(valid1),
        .fill_word_idx(idx1), .fill_data(data1), .fill_done(done1),
        .mem_en(en1), .mem_addr(mem_addr1), .mem_rdata(rdata1),
        .mem_rvalid(rvalid1), .err_rvalid(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipelined memories: return issued address' data 4 cycles later.
    always @(posedge clk) begin
        m0_v <= {m0_v[2:0], en0};
        m1_v <= {m1_v[2:0], en1};
        for (int k = 3; k > 0; k--) begin
            m0_a[k] <= m0_a[k-1];
            m1_a[k] <= m1_a[k-1];
        end
        m0_a[0] <= mem_addr0;
        m1_a[0] <= mem_addr1;
    end

    assign rvalid0 = m0_v[3] | inj;
    assign rdata0  = mdata(m0_a[3]);
    assign rvalid1 = m1_v[3];
    assign rdata1  = mdata(m1_a[3]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // k = cycles since the fill's first issue cycle; negative means no fill active.
    task automatic check_fill_cycle(input int k, input logic [15:0] b, input logic [1:0] gx);
        logic       e_en, e_vld, e_done;
        logic [1:0] e_grant;
        e_en    = (k >= 0 && k <= 7);
        e_vld   = (k >= 5 && k <= 12);
        e_done  = (k == 12);
        e_grant = (k >= 0 && k <= 12) ? gx : 2'b00;
        chk("mem_en", 32'(en0), 32'(e_en));
        chk("mem_addr", 32'(mem_addr0), e_en ? 32'(b + 16'(2 * k)) : 32'd0);
        chk("fill_valid", 32'(valid0), 32'(e_vld));
        if (e_vld) begin
            chk("fill_word_idx", 32'(idx0), 32'(k - 5));
            chk("fill_data", 32'(data0), 32'(mdata(b + 16'(2 * (k - 5)))));
        end
        chk("fill_done", 32'(done0), 32'(e_done));
        chk("fill_grant", 32'(grant0), 32'(e_grant));
        chk("fill_busy", 32'(busy0), 32'(req0 & ~(e_done ? gx : 2'b00)));
        chk("err_rvalid", 32'(err0), 32'd0);
    endtask

    initial begin
        int         f;
        int         k;
        logic [1:0] gexp;

        rst_n = 1'b0;
        req0  = 2'b00;
        req1  = 2'b00;
        addr0 = '0;
        addr1 = '0;
        inj   = 1'b0;

        // Reset: outputs quiet, busy mirrors miss_req.
        tick();
        tick();
        chk("rst_grant", 32'(grant0), 32'd0);
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_mem_en", 32'(en0), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        req0 = 2'b10;
        #1;
        chk("rst_busy_follows_req", 32'(busy0), 32'h2);
        req0 = 2'b00;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("flush_mem_en", 32'(en0), 32'd0);
            chk("flush_grant", 32'(grant0), 32'd0);
            chk("flush_valid", 32'(valid0), 32'd0);
        end

        // Single miss from requester 0 at byte 0x0046.
        req0  = 2'b01;
        addr0 = {16'h0000, 16'h0046};
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 14) req0 = 2'b00;
            #1;
            check_fill_cycle(c - 1, 16'h0040, 2'b01);
        end

        // Both request together, fixed priority: 0 first, 1 granted at cycle 15.
        req0  = 2'b11;
        addr0 = {16'h12F3, 16'h0046};
        for (int c = 1; c <= 29; c++) begin
            tick();
            if (c == 14) req0[0] = 1'b0;
            if (c == 28) req0[1] = 1'b0;
            #1;
            if (c < 15) check_fill_cycle(c - 1, 16'h0040, 2'b01);
            else        check_fill_cycle(c - 15, 16'h12F0, 2'b10);
        end

        // Round-robin instance with both requesters held: grants 01, 10, 01.
        req1  = 2'b11;
        addr1 = {16'h2222, 16'h1108};
        for (int c = 1; c <= 42; c++) begin
            tick();
            if (c == 42) req1 = 2'b00;
            #1;
            f    = (c - 1) / 14;
            k    = (c - 1) % 14;
            gexp = (k <= 12) ? ((f % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("rr_grant", 32'(grant1), 32'(gexp));
            chk("rr_done", 32'(done1), 32'(k == 12));
            if (k == 0) chk("rr_mem_addr", 32'(mem_addr1), (f % 2 == 0) ? 32'h1100 : 32'h2220);
        end

        // Reset at edge 10 of a fill: no done, stale returns absorbed, refill correct.
        req0  = 2'b01;
        addr0 = {16'h0000, 16'h0A5C};
        for (int c = 1; c <= 29; c++) begin
            tick();
            if (c == 10) rst_n = 1'b0;
            if (c == 11) rst_n = 1'b1;
            if (c == 29) req0 = 2'b00;
            #1;
            if (c <= 10)      check_fill_cycle(c - 1, 16'h0A50, 2'b01);
            else if (c <= 15) check_fill_cycle(-1, 16'h0A50, 2'b01);
            else              check_fill_cycle(c - 16, 16'h0A50, 2'b01);
        end

        // Stray return in IDLE: sticky error, no fill_valid.
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        #1;
        chk("err_set", 32'(err0), 32'd1);
        chk("err_no_valid", 32'(valid0), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("err_sticky", 32'(err0), 32'd1);
            chk("err_no_valid_later", 32'(valid0), 32'd0);
            chk("err_idle_mem_en", 32'(en0), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
